// File: rtl/pipe.sv
// Scrolling 8x8 LED column display: a divided tick shifts columns from the
// entry column (red[0]) toward the exit column (red[7]); crash forces all-on.
module pipe #(
    parameter int SHIFT_DIV = 129,
    parameter int SPACING   = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            crash,
    input  logic [7:0]      current,
    output logic [7:0][7:0] red
);

    localparam int DIV_W = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
    localparam int PH_W  = (SPACING > 1) ? $clog2(SPACING) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SHIFT_DIV - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(SPACING - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic             tick;
    logic [7:0]       red0;
    logic [7:1][7:0]  red_q, red_d;

    always_comb begin
        tick  = (div_q == DIV_LAST);
        div_d = tick ? '0 : div_q + DIV_W'(1);
    end

    // Phase freezes during crash so injection spacing resumes where it left off.
    always_comb begin
        phase_d = phase_q;
        if (tick && !crash) begin
            phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
        end
    end

    always_comb begin
        red0 = 8'h00;
        if (!reset) begin
            red0 = 8'h00;
        end else if (crash) begin
            red0 = 8'hFF;
        end else if (phase_q == PH_LAST) begin
            red0 = current;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi < 8; gi++) begin : g_col
            logic [7:0] shift_in;
            if (gi == 1) begin : g_entry
                assign shift_in = red0;
            end else begin : g_chain
                assign shift_in = red_q[gi-1];
            end

            always_comb begin
                red_d[gi] = red_q[gi];
                if (crash) begin
                    red_d[gi] = 8'hFF;
                end else if (tick) begin
                    red_d[gi] = shift_in;
                end
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!reset) begin
            div_q   <= '0;
            phase_q <= '0;
            red_q   <= '0;
        end else begin
            div_q   <= div_d;
            phase_q <= phase_d;
            red_q   <= red_d;
        end
    end

    assign red = {red_q, red0};

endmodule

// File: tb/tb_pipe.sv
// Bench for pipe: four parameterisations share reset/crash, each with its own
// current input, checked against a cycle-count based model of the display.
module tb_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       crash;
    logic [7:0] cur [4];
    logic [7:0][7:0] red_a, red_b, red_c, red_d;

    pipe #(.SHIFT_DIV(1),   .SPACING(4)) u_a (.clock(clk), .reset(reset), .crash(crash), .current(cur[0]), .red(red_a));
    pipe #(.SHIFT_DIV(129), .SPACING(4)) u_b (.clock(clk), .reset(reset), .crash(crash), .current(cur[1]), .red(red_b));
    pipe #(.SHIFT_DIV(1),   .SPACING(1)) u_c (.clock(clk), .reset(reset), .crash(crash), .current(cur[2]), .red(red_c));
    pipe #(.SHIFT_DIV(5),   .SPACING(3)) u_d (.clock(clk), .reset(reset), .crash(crash), .current(cur[3]), .red(red_d));

    int checks   = 0;
    int failures = 0;
    int txn      = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s txn=%0d got=%h exp=%h", tag, txn, got, exp);
        end
    endtask

    // Model: edges since reset, number of non-crash ticks, and the column list.
    int         m_sd [4] = '{1, 129, 1, 5};
    int         m_sp [4] = '{4, 4, 1, 3};
    int         m_edges [4];
    int         m_ticks [4];
    logic [7:0] m_col [4][8];

    function automatic logic [7:0] m_entry(input int n);
        if (!reset)                             return 8'h00;
        if (crash)                              return 8'hFF;
        if ((m_ticks[n] % m_sp[n]) == m_sp[n] - 1) return cur[n];
        return 8'h00;
    endfunction

    function automatic logic [63:0] m_red(input int n);
        logic [63:0] v;
        v[7:0] = m_entry(n);
        for (int k = 1; k < 8; k++) v[8*k +: 8] = m_col[n][k];
        return v;
    endfunction

    task automatic m_edge();
        for (int n = 0; n < 4; n++) begin
            logic [7:0] e;
            logic       t;
            e = m_entry(n);
            if (!reset) begin
                m_edges[n] = 0;
                m_ticks[n] = 0;
                for (int k = 1; k < 8; k++) m_col[n][k] = 8'h00;
            end else begin
                t = ((m_edges[n] + 1) % m_sd[n]) == 0;
                m_edges[n]++;
                if (crash) begin
                    for (int k = 1; k < 8; k++) m_col[n][k] = 8'hFF;
                end else if (t) begin
                    for (int k = 7; k > 1; k--) m_col[n][k] = m_col[n][k-1];
                    m_col[n][1] = e;
                    m_ticks[n]++;
                end
            end
        end
    endtask

    // Called right after a negedge with inputs already driven.
    task automatic sample();
        #1;
        $display("txn %0d reset=%b crash=%b cur=%h/%h/%h/%h", txn, reset, crash, cur[0], cur[1], cur[2], cur[3]);
        check("red_a", red_a, m_red(0));
        check("red_b", red_b, m_red(1));
        check("red_c", red_c, m_red(2));
        check("red_d", red_d, m_red(3));
    endtask

    task automatic advance();
        @(posedge clk);
        m_edge();
        @(negedge clk);
        txn++;
    endtask

    logic [7:0] entry_seq [4] = '{8'h00, 8'h00, 8'h00, 8'h04};
    logic [7:0] step_seq  [4] = '{8'h04, 8'h02, 8'h01, 8'h10};

    initial begin
        reset = 1'b0;
        crash = 1'b0;
        for (int n = 0; n < 4; n++) cur[n] = 8'h00;
        @(negedge clk);
        @(negedge clk);

        // Reset held with crash and busy inputs: everything reads zero.
        crash = 1'b1;
        cur[0] = 8'hA5; cur[2] = 8'h5A;
        @(posedge clk); m_edge(); @(negedge clk);
        sample();
        check("rst_red0_crash", {56'h0, red_a[0]}, 64'h0);
        advance();

        // Directed scroll after release.
        reset = 1'b1;
        crash = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cur[0] = 8'h04;
            cur[1] = 8'h01;
            cur[2] = (i < 4) ? step_seq[i] : 8'($urandom);
            cur[3] = 8'($urandom);
            crash  = (i == 14 || i == 15);
            sample();
            if (i < 4)   check("a_entry_seq", {56'h0, red_a[0]}, {56'h0, entry_seq[i]});
            if (i == 4)  check("a_red1", {56'h0, red_a[1]}, 64'h04);
            if (i == 4)  check("c_steps", {32'h0, red_c[4:1]}, {32'h0, 32'h04020110});
            if (i == 10) check("a_red7_in", {56'h0, red_a[7]}, 64'h04);
            if (i == 11) check("a_red7_out", {56'h0, red_a[7]}, 64'h00);
            if (i == 14) check("a_crash_red0", {56'h0, red_a[0]}, 64'hFF);
            if (i == 15) check("a_crash_all", red_a, {64{1'b1}});
            if (i == 16) check("a_post_crash", {8'h0, red_a[7:1]}, {8'h0, {56{1'b1}}});
            advance();
        end

        // Randomized run.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 599) != 0);
            crash = ($urandom_range(0, 24) == 0);
            for (int n = 0; n < 4; n++) cur[n] = 8'($urandom);
            sample();
            advance();
        end

        // Reset coincident with crash and tick.
        reset = 1'b0;
        crash = 1'b1;
        sample();
        advance();
        reset = 1'b1;
        crash = 1'b0;
        cur[0] = 8'hFF;
        sample();
        check("rstcrash_cols", {8'h0, red_a[7:1]}, 64'h0);
        check("rstcrash_phase0", {56'h0, red_a[0]}, 64'h00);
        advance();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
